// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan mux: active-low glyphs ({g,f,e,d,c,b,a}),
// the dash and blank codes, the all-off anode pattern and the scan FSM state type.
package ssd_pkg;

  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
  localparam logic [3:0] c_ANODE_OFF = 4'b1111;

  // Element n is the glyph for value n (F first because concatenation is MSB-first).
  localparam logic [15:0][6:0] c_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit to active-low 7-segment decode; zero latency, no flow control.
// Decimal mode (c_HEX_DEC = 9) shows a dash for 10-15, hex mode (15) shows A,b,C,d,E,F.
module ssd_hex_decoder #(
  parameter int c_HEX_DEC = 9
) (
  input  logic [3:0] i_Val,
  output logic [6:0] o_Seg
);
  import ssd_pkg::*;

  always_comb begin
    o_Seg = c_GLYPHS[i_Val];
    if (c_HEX_DEC == 9 && i_Val > 4'd9) begin
      o_Seg = c_SEG_DASH;
    end
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Four-digit multiplexed seven-segment driver with a blanked dead-time at the start of each slot.
// Outputs are registered (1 cycle behind internal state); free-running, no backpressure.
module ssd_scan_mux #(
  parameter int c_HEX_DEC     = 9,
  parameter int c_SLOT_CYCLES = 100000,
  parameter int c_DEADTIME    = 1000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  input  logic [3:0] i_DP_mask,
  input  logic       i_Blank_LZ,
  output logic [3:0] o_Anode,
  output logic [6:0] o_Segments,
  output logic       o_DP
);
  import ssd_pkg::*;

  localparam int                 c_CNT_W    = $clog2(c_SLOT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SLOT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_DEAD = c_CNT_W'(c_DEADTIME);

  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]         r_idx, w_idx_nxt;
  scan_state_t        r_state, w_state_nxt;

  logic [3:0] r_snap_d1, r_snap_d2, r_snap_d3, r_snap_d4, r_snap_dp;
  logic       r_snap_lz;

  logic [3:0] r_anode, w_anode_nxt;
  logic [6:0] r_seg, w_seg_nxt;
  logic       r_dp, w_dp_nxt;

  logic       w_frame_start;
  logic       w_lz_blank;
  logic [3:0] w_cur_val;
  logic [6:0] w_dec_seg;

  assign w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_state <= ST_BLANK;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end

  // The whole frame displays one coherent snapshot, so digits never tear mid-scan.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_snap_d1 <= 4'd0;
      r_snap_d2 <= 4'd0;
      r_snap_d3 <= 4'd0;
      r_snap_d4 <= 4'd0;
      r_snap_dp <= 4'd0;
      r_snap_lz <= 1'b0;
    end else if (w_frame_start) begin
      r_snap_d1 <= i_Digit_1_val;
      r_snap_d2 <= i_Digit_2_val;
      r_snap_d3 <= i_Digit_3_val;
      r_snap_d4 <= i_Digit_4_val;
      r_snap_dp <= i_DP_mask;
      r_snap_lz <= i_Blank_LZ;
    end
  end

  always_comb begin
    w_cur_val  = r_snap_d4;
    w_lz_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_cur_val  = r_snap_d1;
        w_lz_blank = r_snap_lz && (r_snap_d1 == 4'd0);
      end
      2'd1: begin
        w_cur_val  = r_snap_d2;
        w_lz_blank = r_snap_lz && (r_snap_d1 == 4'd0) && (r_snap_d2 == 4'd0);
      end
      2'd2: begin
        w_cur_val  = r_snap_d3;
        w_lz_blank = r_snap_lz && (r_snap_d1 == 4'd0) && (r_snap_d2 == 4'd0)
                     && (r_snap_d3 == 4'd0);
      end
      default: begin
        w_cur_val  = r_snap_d4;
        w_lz_blank = 1'b0;
      end
    endcase
  end

  ssd_hex_decoder #(
    .c_HEX_DEC(c_HEX_DEC)
  ) u_decoder (
    .i_Val(w_cur_val),
    .o_Seg(w_dec_seg)
  );

  always_comb begin
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_state_nxt = r_state;
    if (r_cnt == c_CNT_LAST) begin
      w_cnt_nxt = '0;
      w_idx_nxt = r_idx + 2'd1;
    end
    w_state_nxt = (w_cnt_nxt < c_CNT_DEAD) ? ST_BLANK : ST_DRIVE;

    w_anode_nxt = c_ANODE_OFF;
    w_seg_nxt   = c_SEG_BLANK;
    w_dp_nxt    = 1'b1;
    if (r_state == ST_DRIVE) begin
      // Anode bit 3 is digit 1, so the active bit is the inverted index.
      w_anode_nxt[~r_idx] = 1'b0;
      w_seg_nxt           = w_lz_blank ? c_SEG_BLANK : w_dec_seg;
      w_dp_nxt            = ~(r_snap_dp[~r_idx] & ~w_lz_blank);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_anode <= c_ANODE_OFF;
      r_seg   <= c_SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_anode <= w_anode_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
    end
  end

  assign o_Anode    = r_anode;
  assign o_Segments = r_seg;
  assign o_DP       = r_dp;

endmodule
